// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side UART sequencer.
// Serialises one frame per accepted byte: start bit, DBIT data bits (LSB
// first), optional even-parity bit, then SB_TICK oversampled stop ticks.
// Each bit lasts 16 ticks of the external 16x baud tick (s_tick).
// Drives baud_en so the baud generator runs only while a frame is in flight.
// Optional feature: define UART_TX_PARITY_EN to add the even-parity bit.
module uart_tx_ctrl #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   output logic            baud_en,
   input  logic            tx_valid,
   output logic            tx_ready,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
   localparam logic [5:0]    S_BIT_END = 6'd15;
   localparam logic [5:0]    S_STOP_END = 6'(SB_TICK - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic [5:0]      s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
`ifdef UART_TX_PARITY_EN
   logic            p;
`endif

   // Frame sequencer; tx and status outputs are registered from next-state values
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         tx           <= 1'b1;
         tx_ready     <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
         baud_en      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         p            <= 1'b0;
`endif
      end else begin
         tx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               baud_en <= 1'b0;
               tx_busy <= 1'b0;
               if (tx_valid && tx_ready) begin
                  b        <= din;
                  s        <= '0;
                  state    <= START;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  baud_en  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  p        <= ^din;
`endif
               end else begin
                  // ready rises one cycle after STOP exits, never during the done pulse
                  tx_ready <= 1'b1;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == S_BIT_END) begin
                     s     <= '0;
                     n     <= '0;
                     state <= DATA;
                     tx    <= b[0];
                  end else begin
                     s <= s + 6'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == S_BIT_END) begin
                     s <= '0;
                     b <= {1'b0, b[DBIT-1:1]};
                     if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= p;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                     end else begin
                        n  <= n + NW'(1);
                        tx <= b[1];
                     end
                  end else begin
                     s <= s + 6'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == S_BIT_END) begin
                     s     <= '0;
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     s <= s + 6'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s == S_STOP_END) begin
                     s            <= '0;
                     state        <= IDLE;
                     tx           <= 1'b1;
                     tx_done_tick <= 1'b1;
                     baud_en      <= 1'b0;
                     tx_busy      <= 1'b0;
                  end else begin
                     s <= s + 6'd1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               baud_en  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl: an 8-bit/1-stop instance and a
// 7-bit/2-stop instance share the clock and reset; each has a 16x tick model
// that pulses every 4 clk while baud_en is high.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick_en = 1'b1;
   logic       sel = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic       tx_valid_a = 1'b0;
   logic [7:0] din_a = 8'h00;
   logic       s_tick_a, baud_en_a, tx_ready_a, tx_a, tx_busy_a, tx_done_a;
   logic [1:0] tcnt_a;

   logic       tx_valid_b = 1'b0;
   logic [6:0] din_b = 7'h00;
   logic       s_tick_b, baud_en_b, tx_ready_b, tx_b, tx_busy_b, tx_done_b;
   logic [1:0] tcnt_b;

   logic m_tick, m_baud, m_ready, m_tx, m_busy, m_done;

   always #5 clk = ~clk;

   // Baud tick models: free-running 4-clk divider held in reset while baud_en is low
   always @(posedge clk) begin
      if (!baud_en_a) tcnt_a <= 2'd0;
      else            tcnt_a <= tcnt_a + 2'd1;
      if (!baud_en_b) tcnt_b <= 2'd0;
      else            tcnt_b <= tcnt_b + 2'd1;
   end

   assign s_tick_a = baud_en_a && tick_en && (tcnt_a == 2'd3);
   assign s_tick_b = baud_en_b && tick_en && (tcnt_b == 2'd3);

   assign m_tick  = sel ? s_tick_b   : s_tick_a;
   assign m_baud  = sel ? baud_en_b  : baud_en_a;
   assign m_ready = sel ? tx_ready_b : tx_ready_a;
   assign m_tx    = sel ? tx_b       : tx_a;
   assign m_busy  = sel ? tx_busy_b  : tx_busy_a;
   assign m_done  = sel ? tx_done_b  : tx_done_a;

   uart_tx_ctrl #(.DBIT(8), .SB_TICK(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick_a), .baud_en(baud_en_a),
      .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .din(din_a), .tx(tx_a),
      .tx_busy(tx_busy_a), .tx_done_tick(tx_done_a));

   uart_tx_ctrl #(.DBIT(7), .SB_TICK(32)) dut_b (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick_b), .baud_en(baud_en_b),
      .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .din(din_b), .tx(tx_b),
      .tx_busy(tx_busy_b), .tx_done_tick(tx_done_b));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offer a byte at a negedge; returns at the negedge after the transfer edge
   task automatic start_tx(input logic [8:0] d, input bit hold, input string tag,
                           output int waited);
      int w;
      w = 0;
      if (sel) begin din_b = d[6:0]; tx_valid_b = 1'b1; end
      else     begin din_a = d[7:0]; tx_valid_a = 1'b1; end
      while (!m_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_accept"}, (w < 5000) ? 1 : 0, 1);
      check({tag, "_idle_high"}, m_tx, 1);
      @(negedge clk);
      if (!hold) begin
         tx_valid_a = 1'b0;
         tx_valid_b = 1'b0;
      end
      check({tag, "_tx_fall"}, m_tx, 0);
      waited = w;
   endtask

   // Follow one frame from just after transfer to just after tx_done_tick
   task automatic mon_frame(input logic [8:0] d, input int nb, input int sb,
                            input string tag, input bit exact, input bit stall,
                            input int rst_tk);
      logic [15:0] eb;
      int tk, cyc, nk, nf, total, rdy_hi, ben_lo, busy_lo, wave_err, stall_err;
      bit done, stalled;
      eb = '0; tk = 0; cyc = 0; nk = 0; rdy_hi = 0; ben_lo = 0; busy_lo = 0;
      wave_err = 0; stall_err = 0; done = 1'b0; stalled = 1'b0;
      for (int i = 0; i < nb; i++) eb[1+i] = d[i];
      if (PAR == 1) eb[1+nb] = ^d;
      for (int j = 0; j < sb/16; j++) eb[1+nb+PAR+j] = 1'b1;
      nf = 1 + nb + PAR + sb/16;
      total = 16*(1 + nb + PAR) + sb;
      for (int g = 0; g < 20000 && !done; g++) begin
         if (rst_tk >= 0 && tk == rst_tk) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            check({tag, "_rst_tx"}, m_tx, 1);
            check({tag, "_rst_ready"}, m_ready, 1);
            check({tag, "_rst_baud"}, m_baud, 0);
            check({tag, "_rst_busy"}, m_busy, 0);
            begin
               int dn;
               dn = 0;
               for (int k = 0; k < 8; k++) begin
                  if (m_done) dn++;
                  @(negedge clk);
               end
               check({tag, "_rst_no_done"}, dn, 0);
            end
            return;
         end
         if (m_done) begin
            done = 1'b1;
         end else begin
            if (exact && cyc < 4*total && m_tx !== eb[cyc/64]) wave_err++;
            if (m_ready) rdy_hi++;
            if (!m_baud) ben_lo++;
            if (!m_busy) busy_lo++;
            if (nk < nf && tk == 16*nk + 8) begin
               check($sformatf("%s_bit%0d", tag, nk), m_tx, eb[nk]);
               nk++;
            end
            if (stall && !stalled && tk == 68) begin
               stalled = 1'b1;
               tick_en = 1'b0;
               for (int k = 0; k < 200; k++) begin
                  @(negedge clk);
                  if (m_tx !== 1'b0 || m_done || !m_busy || !m_baud) stall_err++;
               end
               tick_en = 1'b1;
            end
            if (m_tick) tk++;
            cyc++;
            @(negedge clk);
         end
      end
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_ticks"}, tk, total);
      check({tag, "_bits_sampled"}, nk, nf);
      if (exact) begin
         check({tag, "_wave_err"}, wave_err, 0);
         check({tag, "_done_cyc"}, cyc, 4*total);
      end
      if (stall) check({tag, "_stall_err"}, stall_err, 0);
      check({tag, "_ready_in_frame"}, rdy_hi, 0);
      check({tag, "_baud_low_in_frame"}, ben_lo, 0);
      check({tag, "_busy_low_in_frame"}, busy_lo, 0);
      check({tag, "_ready_at_done"}, m_ready, 0);
      check({tag, "_baud_at_done"}, m_baud, 0);
      check({tag, "_tx_at_done"}, m_tx, 1);
      @(negedge clk);
      check({tag, "_done_one_pulse"}, m_done, 0);
      check({tag, "_ready_after_done"}, m_ready, 1);
   endtask

   initial begin
      int w;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_a", tx_a, 1);
      check("rst_ready_a", tx_ready_a, 1);
      check("rst_busy_a", tx_busy_a, 0);
      check("rst_done_a", tx_done_a, 0);
      check("rst_baud_a", baud_en_a, 0);
      check("rst_tx_b", tx_b, 1);
      check("rst_ready_b", tx_ready_b, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 0x55 with cycle-exact waveform
      sel = 1'b0;
      start_tx(9'h055, 1'b0, "f55", w);
      mon_frame(9'h055, 8, 16, "f55", 1'b1, 1'b0, -1);
      repeat (3) @(negedge clk);

      // Back-to-back 0xA3 then 0x0F with tx_valid held high
      start_tx(9'h0A3, 1'b1, "fA3", w);
      mon_frame(9'h0A3, 8, 16, "fA3", 1'b1, 1'b0, -1);
      start_tx(9'h00F, 1'b0, "f0F", w);
      check("b2b_gap", w, 0);
      mon_frame(9'h00F, 8, 16, "f0F", 1'b1, 1'b0, -1);
      repeat (3) @(negedge clk);

      // Tick stall during data bit 3 of 0xF0
      start_tx(9'h0F0, 1'b0, "fF0", w);
      mon_frame(9'h0F0, 8, 16, "fF0", 1'b0, 1'b1, -1);
      repeat (3) @(negedge clk);

      // Reset during data bit 5, then a clean 0x81 frame
      start_tx(9'h0C5, 1'b0, "fRst", w);
      mon_frame(9'h0C5, 8, 16, "fRst", 1'b0, 1'b0, 16*6 + 8);
      start_tx(9'h081, 1'b0, "f81", w);
      mon_frame(9'h081, 8, 16, "f81", 1'b1, 1'b0, -1);
      repeat (3) @(negedge clk);

      // Parity-sensitive patterns
      start_tx(9'h003, 1'b0, "f03", w);
      mon_frame(9'h003, 8, 16, "f03", 1'b1, 1'b0, -1);
      repeat (2) @(negedge clk);
      start_tx(9'h007, 1'b0, "f07", w);
      mon_frame(9'h007, 8, 16, "f07", 1'b1, 1'b0, -1);
      repeat (3) @(negedge clk);

      // DBIT=7, two stop bits, 0x7F
      sel = 1'b1;
      start_tx(9'h07F, 1'b0, "b7F", w);
      mon_frame(9'h07F, 7, 32, "b7F", 1'b0, 1'b0, -1);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
